// File: rtl/cart_pkg.sv
// ============================================================================
//  Module : cart_pkg
//  Brief  : Shared types for the cartridge SDRAM arbiter (FSM states, port ids).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_SLOT      = 2'd2,
        ST_ACK       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_LD = 2'd0,
        PORT_A  = 2'd1,
        PORT_B  = 2'd2
    } port_t;

    localparam logic [1:0] c_DS_BOTH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/cart_rr_pick.sv
// ============================================================================
//  Module : cart_rr_pick
//  Brief  : Loader-first, then A/B round-robin winner selection (combinational).
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module cart_rr_pick
    import cart_pkg::*;
(
    input  logic  i_ld_req,
    input  logic  i_a_req,
    input  logic  i_b_req,
    input  logic  i_prefer_b,
    output logic  o_valid,
    output port_t o_port
);

    always_comb begin
        o_valid = i_ld_req | i_a_req | i_b_req;
        o_port  = PORT_LD;
        if (i_ld_req) begin
            o_port = PORT_LD;
        end else if (i_a_req && i_b_req) begin
            o_port = i_prefer_b ? PORT_B : PORT_A;
        end else if (i_a_req) begin
            o_port = PORT_A;
        end else if (i_b_req) begin
            o_port = PORT_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cart_sdram_arbiter.sv
// ============================================================================
//  Module : cart_sdram_arbiter
//  Brief  : Arbitrates loader, CPU PRG and PPU CHR ports onto sync-slotted SDRAM.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module cart_sdram_arbiter
    import cart_pkg::*;
#(
    parameter int ADDR_W  = 21,
    parameter int WADDR_W = 20
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sync,

    input  logic               ld_req,
    input  logic [WADDR_W-1:0] ld_addr,
    input  logic [15:0]        ld_wdata,
    output logic               ld_ack,

    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDR_W-1:0]  a_addr,
    input  logic [7:0]         a_wdata,
    output logic [7:0]         a_rdata,
    output logic               a_ack,

    input  logic               b_req,
    input  logic [ADDR_W-1:0]  b_addr,
    output logic [7:0]         b_rdata,
    output logic               b_ack,

    output logic [WADDR_W-1:0] sd_addr,
    output logic [15:0]        sd_din,
    input  logic [15:0]        sd_dout,
    output logic               sd_we,
    output logic               sd_oe,
    output logic [1:0]         sd_ds,

    output logic               busy
);

    state_t               r_state;
    state_t               w_state_nxt;
    port_t                r_port;
    logic                 r_prefer_b;
    logic [WADDR_W-1:0]   r_addr;
    logic [15:0]          r_din;
    logic                 r_we;
    logic [1:0]           r_ds;
    logic                 r_lane;

    logic                 w_pick_valid;
    port_t                w_pick;
    logic [WADDR_W-1:0]   w_cmd_addr;
    logic [15:0]          w_cmd_din;
    logic                 w_cmd_we;
    logic [1:0]           w_cmd_ds;
    logic                 w_cmd_lane;
    logic [7:0]           w_rbyte;

    cart_rr_pick u_pick (
        .i_ld_req   (ld_req),
        .i_a_req    (a_req),
        .i_b_req    (b_req),
        .i_prefer_b (r_prefer_b),
        .o_valid    (w_pick_valid),
        .o_port     (w_pick)
    );

    // Translate the winner's request into a 16-bit SDRAM word command.
    always_comb begin
        w_cmd_addr = '0;
        w_cmd_din  = '0;
        w_cmd_we   = 1'b0;
        w_cmd_ds   = c_DS_BOTH;
        w_cmd_lane = 1'b0;
        case (w_pick)
            PORT_LD: begin
                w_cmd_addr = ld_addr;
                w_cmd_din  = ld_wdata;
                w_cmd_we   = 1'b1;
            end
            PORT_A: begin
                w_cmd_addr = a_addr[WADDR_W:1];
                w_cmd_din  = {a_wdata, a_wdata};
                w_cmd_we   = a_we;
                w_cmd_lane = a_addr[0];
                if (a_we) begin
                    w_cmd_ds = a_addr[0] ? 2'b10 : 2'b01;
                end
            end
            PORT_B: begin
                w_cmd_addr = b_addr[WADDR_W:1];
                w_cmd_lane = b_addr[0];
            end
            default: begin
                w_cmd_addr = '0;
            end
        endcase
    end

    assign w_rbyte = r_lane ? sd_dout[15:8] : sd_dout[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != ST_IDLE);
        ld_ack      = 1'b0;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                if (sync) begin
                    w_state_nxt = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (sync) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
                ld_ack      = (r_port == PORT_LD);
                a_ack       = (r_port == PORT_A);
                b_ack       = (r_port == PORT_B);
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_port     <= PORT_LD;
            r_prefer_b <= 1'b1;
            r_addr     <= '0;
            r_din      <= '0;
            r_we       <= 1'b0;
            r_ds       <= '0;
            r_lane     <= 1'b0;
            sd_addr    <= '0;
            sd_din     <= '0;
            sd_we      <= 1'b0;
            sd_oe      <= 1'b0;
            sd_ds      <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_port <= w_pick;
                        r_addr <= w_cmd_addr;
                        r_din  <= w_cmd_din;
                        r_we   <= w_cmd_we;
                        r_ds   <= w_cmd_ds;
                        r_lane <= w_cmd_lane;
                        // Loader grants leave the A/B fairness pointer alone.
                        if (w_pick != PORT_LD) begin
                            r_prefer_b <= (w_pick == PORT_A);
                        end
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sync) begin
                        sd_addr <= r_addr;
                        sd_din  <= r_din;
                        sd_we   <= r_we;
                        sd_oe   <= ~r_we;
                        sd_ds   <= r_ds;
                    end
                end
                ST_SLOT: begin
                    if (sync) begin
                        sd_we <= 1'b0;
                        sd_oe <= 1'b0;
                        sd_ds <= '0;
                        if (!r_we && r_port == PORT_A) begin
                            a_rdata <= w_rbyte;
                        end
                        if (!r_we && r_port == PORT_B) begin
                            b_rdata <= w_rbyte;
                        end
                    end
                end
                default: begin
                    sd_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/cart_sdram_arbiter.md
CART_SDRAM_ARBITER -- requirements
Module: cart_sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, byte-address width of ports A and B.
REQ-002 SHALL have parameter WADDR_W, default 20, word-address width of the loader port and SDRAM side.
REQ-003 SHALL have port clock  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sync  input  1  one-cycle pulse marking each SDRAM access-slot boundary.
REQ-006 SHALL have loader ports: ld_req in 1; ld_addr in WADDR_W (word address); ld_wdata in 16; ld_ack out 1.
REQ-007 SHALL have port A (CPU PRG, read/write): a_req in 1; a_we in 1; a_addr in ADDR_W (byte address); a_wdata in 8; a_rdata out 8; a_ack out 1.
REQ-008 SHALL have port B (PPU CHR, read-only): b_req in 1; b_addr in ADDR_W; b_rdata out 8; b_ack out 1.
REQ-009 SHALL have SDRAM-side ports: sd_addr out WADDR_W; sd_din out 16; sd_dout in 16; sd_we out 1; sd_oe out 1; sd_ds out 2 (byte lanes, bit0 = low byte).
REQ-010 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_SYNC, SLOT, ACK.
REQ-012 In IDLE, when any request is high: latch the winner's address, data, direction and port id, then go to WAIT_SYNC.
REQ-013 Priority: loader is absolute; between A and B, round-robin; last-granted pointer toggles only on an A/B grant; pointer resets to B-first.
REQ-014 In WAIT_SYNC, on sync=1: drive the latched command onto the sd_* outputs and go to SLOT.
REQ-015 In SLOT, sd_* outputs SHALL hold constant; on the next sync=1, capture sd_dout and go to ACK.
REQ-016 In ACK: the granted port's ack is high for exactly one cycle, sd_we/sd_oe/sd_ds are driven to 0, and the next state is IDLE.
REQ-017 Loader command: sd_we=1, sd_oe=0, sd_ds=2'b11, sd_din=ld_wdata, sd_addr=ld_addr.
REQ-018 Byte port write: sd_we=1, sd_oe=0, sd_addr=addr[WADDR_W:1], sd_din={wdata,wdata}, sd_ds=2'b01<<addr[0].
REQ-019 Byte port read: sd_we=0, sd_oe=1, sd_ds=2'b11; rdata = addr[0] ? captured[15:8] : captured[7:0].
REQ-020 a_rdata/b_rdata are registered, valid from the ack cycle, and held until that port's next completed read.
REQ-021 Requesters hold req and its inputs until ack, then deassert req in the cycle after ack; the ACK state guarantees the same request is never re-sampled.
REQ-022 Requests arriving outside IDLE wait; none are dropped while held high.
REQ-023 sync=1 in the same cycle the FSM enters WAIT_SYNC is ignored; issue occurs on the next sync.
REQ-024 Latency: from the grant cycle, ack follows the second subsequent sync by exactly 1 cycle.

Reset
REQ-025 Reset SHALL force IDLE from any state, aborting any in-flight access with no ack issued.
REQ-026 Reset values: all acks 0, sd_we/sd_oe 0, sd_ds 0, sd_addr/sd_din 0, a_rdata/b_rdata 0, busy 0, RR pointer = B.

Structure
REQ-027 The FSM state enum and port-id encoding (LD, A, B) SHALL live in the shared cart package.
REQ-028 One sub-module, cart_rr_pick, SHALL implement the fixed-plus-round-robin winner selection combinationally.

Verification
REQ-029 Loader write: ld_req, ld_addr=0x00010, ld_wdata=0xBEEF, sync every 8 cycles -> sd_we=1, sd_ds=11, sd_din=BEEF for one full slot; single ld_ack.
REQ-030 A write then read: a_addr=0x00021, a_wdata=0x5A -> sd_addr=0x00010, sd_ds=10, sd_din=5A5A; a subsequent read with sd_dout=0x5A00 -> a_rdata=0x5A.
REQ-031 Contention: A and B requesting continuously from reset -> grants B, A, B, A; loader raised mid-stream wins the next IDLE arbitration.
REQ-032 Latency: grant at cycle 0, syncs at cycles 3 and 11 -> ack at cycle 12; sync coincident with the WAIT_SYNC entry is ignored.
REQ-033 Reset asserted during SLOT -> next cycle IDLE, sd_we=0, no ack; the held request is re-served normally afterward.
